// File: rtl/rename_reg_file_if.sv
// -----------------------------------------------------------------------------
// rename_reg_file_if
//   Bundles every non-clock/reset signal of rename_reg_file.
//   master : issue/commit/branch side (decode, ROB, branch unit)
//   slave  : the register/rename file itself
// Signal groups:
//   control  : rdy (global enable), flush (full pipeline flush)
//   issue    : iss_valid, iss_rs1/rs2/rd(_hv), iss_tag, iss_ckpt
//   ROB read : rob_q1/q2 (tag lookup out), rob_q1/q2_ready, rob_q1/q2_value (in)
//   operands : vj, vk (values), qj, qk (producer tags, 0 = value valid)
//   ckpt     : ckpt_id (slot granted), ckpt_full (no free slot)
//   commit   : cm_valid, cm_rd, cm_tag, cm_value
//   branch   : br_ok, br_mis, br_id
// -----------------------------------------------------------------------------
interface rename_reg_file_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NCKPT = 4
);
    localparam int RW = $clog2(NREG);
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

    logic             rdy;
    logic             flush;
    logic             iss_valid;
    logic             iss_rs1_hv, iss_rs2_hv, iss_rd_hv;
    logic [RW-1:0]    iss_rs1, iss_rs2, iss_rd;
    logic [TAG_W-1:0] iss_tag;
    logic             iss_ckpt;
    logic [TAG_W-1:0] rob_q1, rob_q2;
    logic             rob_q1_ready, rob_q2_ready;
    logic [XLEN-1:0]  rob_q1_value, rob_q2_value;
    logic [XLEN-1:0]  vj, vk;
    logic [TAG_W-1:0] qj, qk;
    logic [CW-1:0]    ckpt_id;
    logic             ckpt_full;
    logic             cm_valid;
    logic [RW-1:0]    cm_rd;
    logic [TAG_W-1:0] cm_tag;
    logic [XLEN-1:0]  cm_value;
    logic             br_ok, br_mis;
    logic [CW-1:0]    br_id;

    modport master (
        output rdy, flush, iss_valid, iss_rs1_hv, iss_rs2_hv, iss_rd_hv,
               iss_rs1, iss_rs2, iss_rd, iss_tag, iss_ckpt,
               rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
               cm_valid, cm_rd, cm_tag, cm_value, br_ok, br_mis, br_id,
        input  rob_q1, rob_q2, vj, vk, qj, qk, ckpt_id, ckpt_full
    );

    modport slave (
        input  rdy, flush, iss_valid, iss_rs1_hv, iss_rs2_hv, iss_rd_hv,
               iss_rs1, iss_rs2, iss_rd, iss_tag, iss_ckpt,
               rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
               cm_valid, cm_rd, cm_tag, cm_value, br_ok, br_mis, br_id,
        output rob_q1, rob_q2, vj, vk, qj, qk, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rename_reg_file.sv
// -----------------------------------------------------------------------------
// rename_reg_file
//   Architectural register values plus a per-register ROB-tag rename table.
//   Resolves up to two issue operands (value or producer tag) combinationally,
//   applies commit writes, and keeps NCKPT rename-table checkpoints for branch
//   recovery (selective free of younger checkpoints) and full flush.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : rename_reg_file_if.slave (issue, ROB lookup, operands, checkpoint,
//          commit and branch-resolution signals)
// Optional feature macro: RRF_COMMIT_BYPASS_EN
//   When defined, an operand whose producer commits in the same cycle takes
//   cm_value directly instead of waiting on the ROB ready/value inputs.
// Parameters must match those of the connected interface instance.
// -----------------------------------------------------------------------------
module rename_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NCKPT = 4
) (
    input logic             clk,
    input logic             rst,
    rename_reg_file_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [RW-1:0]    reg_idx_t;
    typedef struct packed {
        logic [XLEN-1:0] v;
        tag_t            q;
    } opnd_t;

    // Architectural state
    logic [XLEN-1:0]  data_q     [NREG];
    tag_t             tbl_q      [NREG];
    tag_t             ckpt_tbl_q [NCKPT][NREG];
    logic [NCKPT-1:0] ckpt_valid_q;
    logic [NCKPT-1:0] older_q    [NCKPT];   // slots that were live when this slot was taken

    // Next-state values
    tag_t             tbl_nx      [NREG];
    tag_t             ckpt_tbl_nx [NCKPT][NREG];
    logic [NCKPT-1:0] ckpt_valid_nx;
    logic [NCKPT-1:0] older_nx    [NCKPT];

    logic             full;
    logic [CW-1:0]    free_id;
    logic             mis_en, ok_en;
    logic [NCKPT-1:0] mis_free;

    // Lowest free checkpoint slot; reads 0 when every slot is live.
    always_comb begin
        full    = &ckpt_valid_q;
        free_id = '0;
        for (int k = NCKPT - 1; k >= 0; k--) begin
            if (!ckpt_valid_q[k]) free_id = CW'(k);
        end
    end

    // Branch resolution on a dead slot is a no-op; a mispredict overrides br_ok.
    assign mis_en = bus.br_mis & ckpt_valid_q[bus.br_id];
    assign ok_en  = bus.br_ok & ~bus.br_mis & ckpt_valid_q[bus.br_id];

    // A mispredict kills its own slot and every slot taken while it was live.
    always_comb begin
        mis_free = '0;
        for (int k = 0; k < NCKPT; k++) mis_free[k] = older_q[k][bus.br_id];
        mis_free[bus.br_id] = 1'b1;
        mis_free = mis_free & ckpt_valid_q;
    end

    always_comb begin
        // NOTE: every variable gets a default before any condition so no path leaves it unassigned and no latch is inferred.
        ckpt_valid_nx = ckpt_valid_q;
        for (int k = 0; k < NCKPT; k++) older_nx[k] = older_q[k];

        // Commit clears a mapping only if it still names the committing tag,
        // both in the live table and in every checkpoint copy.
        for (int r = 0; r < NREG; r++) begin
            tbl_nx[r] = tbl_q[r];
            if (bus.cm_valid && bus.cm_rd == reg_idx_t'(r) && tbl_q[r] == bus.cm_tag)
                tbl_nx[r] = '0;
            for (int k = 0; k < NCKPT; k++) begin
                ckpt_tbl_nx[k][r] = ckpt_tbl_q[k][r];
                if (bus.cm_valid && bus.cm_rd == reg_idx_t'(r) && ckpt_tbl_q[k][r] == bus.cm_tag)
                    ckpt_tbl_nx[k][r] = '0;
            end
        end

        if (bus.flush) begin
            for (int r = 0; r < NREG; r++) tbl_nx[r] = '0;
            ckpt_valid_nx = '0;
            for (int k = 0; k < NCKPT; k++) older_nx[k] = '0;
        end else if (mis_en) begin
            // Recover from the commit-cleaned copy so a same-cycle commit is not lost.
            for (int r = 0; r < NREG; r++) tbl_nx[r] = ckpt_tbl_nx[bus.br_id][r];
            ckpt_valid_nx = ckpt_valid_q & ~mis_free;
            for (int k = 0; k < NCKPT; k++) older_nx[k] = older_q[k] & ~mis_free;
        end else begin
            // Issue is applied after the commit clear, so the new tag wins.
            if (bus.iss_valid && bus.iss_rd_hv && bus.iss_rd != '0)
                tbl_nx[bus.iss_rd] = bus.iss_tag;
            if (bus.iss_valid && bus.iss_ckpt && !full) begin
                for (int r = 0; r < NREG; r++) ckpt_tbl_nx[free_id][r] = tbl_nx[r];
                ckpt_valid_nx[free_id] = 1'b1;
                older_nx[free_id]      = ckpt_valid_q;
            end
            // Applied after allocation so a freed slot never lingers in a new mask.
            if (ok_en) begin
                ckpt_valid_nx[bus.br_id] = 1'b0;
                for (int k = 0; k < NCKPT; k++) older_nx[k][bus.br_id] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the register file is a flop array whose reset value is architecturally visible, so every entry is cleared explicitly.
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tbl_q[r]  <= '0;
                for (int k = 0; k < NCKPT; k++) ckpt_tbl_q[k][r] <= '0;
            end
            ckpt_valid_q <= '0;
            for (int k = 0; k < NCKPT; k++) older_q[k] <= '0;
        end else if (bus.rdy) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            if (bus.cm_valid && bus.cm_rd != '0) data_q[bus.cm_rd] <= bus.cm_value;
            for (int r = 0; r < NREG; r++) begin
                tbl_q[r] <= tbl_nx[r];
                for (int k = 0; k < NCKPT; k++) ckpt_tbl_q[k][r] <= ckpt_tbl_nx[k][r];
            end
            ckpt_valid_q <= ckpt_valid_nx;
            for (int k = 0; k < NCKPT; k++) older_q[k] <= older_nx[k];
        end
    end

    // ---------------------------------------------------------------- operands
    function automatic opnd_t resolve(
        input logic            en,
        input reg_idx_t        rs,
        input tag_t            t,
        input logic            byp,
        input logic            rob_rdy,
        input logic [XLEN-1:0] rob_val,
        input logic [XLEN-1:0] arch_val,
        input logic [XLEN-1:0] byp_val
    );
        opnd_t o;
        o.v = '0;
        o.q = '0;
        if (en && rs != '0) begin
            if (t == '0)    o.v = arch_val;
            else if (byp)   o.v = byp_val;
            else if (rob_rdy) o.v = rob_val;
            else            o.q = t;
        end
        return o;
    endfunction

    tag_t  tag1, tag2;
    logic  byp1, byp2;
    opnd_t op1, op2;

    assign tag1 = tbl_q[bus.iss_rs1];
    assign tag2 = tbl_q[bus.iss_rs2];

`ifdef RRF_COMMIT_BYPASS_EN
    assign byp1 = bus.cm_valid && bus.cm_rd == bus.iss_rs1 && tag1 == bus.cm_tag;
    assign byp2 = bus.cm_valid && bus.cm_rd == bus.iss_rs2 && tag2 == bus.cm_tag;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign op1 = resolve(bus.iss_valid & bus.iss_rs1_hv, bus.iss_rs1, tag1, byp1,
                         bus.rob_q1_ready, bus.rob_q1_value, data_q[bus.iss_rs1], bus.cm_value);
    assign op2 = resolve(bus.iss_valid & bus.iss_rs2_hv, bus.iss_rs2, tag2, byp2,
                         bus.rob_q2_ready, bus.rob_q2_value, data_q[bus.iss_rs2], bus.cm_value);

    assign bus.rob_q1    = tag1;
    assign bus.rob_q2    = tag2;
    assign bus.vj        = op1.v;
    assign bus.qj        = op1.q;
    assign bus.vk        = op2.v;
    assign bus.qk        = op2.q;
    assign bus.ckpt_id   = free_id;
    assign bus.ckpt_full = full;

    // Branch resolution must name a live checkpoint.
    br_slot_live: assert property (@(posedge clk) disable iff (rst)
        (bus.rdy && (bus.br_ok || bus.br_mis)) |-> ckpt_valid_q[bus.br_id]);

endmodule
